dac_palette_ctrl: RTL and testbench

//  VGA-style palette port controller. Decodes CPU port I/O at 3C7h/3C8h/3C9h and

---
 rtl/dac_palette_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dac_palette_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_palette_ctrl.sv
// VGA-style palette port controller: decodes the index/data ports, packs 6-bit RGB
// triplets into RGB565 palette writes, and prefetches entries for data-port readback.
module dac_palette_ctrl #(
   parameter logic [15:0] BASE     = 16'h03C0,
   parameter int          READ_LAT = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] port_a,
   input  logic        port_w,
   input  logic        port_r,
   input  logic [7:0]  port_o,
   output logic [7:0]  port_i,
   output logic        port_sel,
   output logic [7:0]  dac_a,
   output logic [15:0] dac_d,
   output logic        dac_w,
   input  logic [15:0] dac_q
);

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_LATCH} fetch_e;

   localparam logic [15:0] A_RIDX   = BASE + 16'd7;
   localparam logic [15:0] A_WIDX   = BASE + 16'd8;
   localparam logic [15:0] A_DATA   = BASE + 16'd9;
   localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

   logic [7:0]  widx_q, widx_d, ridx_q, ridx_d, wr_addr_q, wr_addr_d;
   logic [1:0]  wphase_q, wphase_d, rphase_q, rphase_d, cnt_q, cnt_d;
   logic        mode_q, mode_d, dac_w_q, dac_w_d;
   logic [5:0]  r6_q, r6_d, g6_q, g6_d;
   logic [15:0] dac_d_q, dac_d_d, rbuf_q, rbuf_d;
   fetch_e      state_q, state_d;

   logic hit_ridx, hit_widx, hit_data;
   logic fetch_start;

   assign hit_ridx = (port_a == A_RIDX);
   assign hit_widx = (port_a == A_WIDX);
   assign hit_data = (port_a == A_DATA);
   assign port_sel = hit_ridx | hit_widx | hit_data;

   // A pending palette write owns the address bus for its single cycle.
   assign dac_a = dac_w_q ? wr_addr_q : ridx_q;
   assign dac_d = dac_d_q;
   assign dac_w = dac_w_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      widx_d      = widx_q;
      ridx_d      = ridx_q;
      wphase_d    = wphase_q;
      rphase_d    = rphase_q;
      mode_d      = mode_q;
      r6_d        = r6_q;
      g6_d        = g6_q;
      wr_addr_d   = wr_addr_q;
      dac_d_d     = dac_d_q;
      dac_w_d     = 1'b0;
      fetch_start = 1'b0;

      if (port_w && hit_widx) begin
         widx_d   = port_o;
         wphase_d = 2'd0;
         mode_d   = 1'b0;
      end

      if (port_w && hit_data) begin
         case (wphase_q)
            2'd0: begin
               r6_d     = port_o[5:0];
               wphase_d = 2'd1;
            end
            2'd1: begin
               g6_d     = port_o[5:0];
               wphase_d = 2'd2;
            end
            default: begin
               dac_w_d   = 1'b1;
               wr_addr_d = widx_q;
               dac_d_d   = {r6_q[5:1], g6_q, port_o[5:1]};
               widx_d    = widx_q + 8'd1;
               wphase_d  = 2'd0;
            end
         endcase
      end

      if (port_r && hit_data) begin
         if (rphase_q == 2'd2) begin
            rphase_d    = 2'd0;
            ridx_d      = ridx_q + 8'd1;
            fetch_start = 1'b1;
         end else begin
            rphase_d = rphase_q + 2'd1;
         end
      end

      if (port_w && hit_ridx) begin
         ridx_d      = port_o;
         rphase_d    = 2'd0;
         mode_d      = 1'b1;
         fetch_start = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         F_REQ: begin
            if (!dac_w_q) begin
               state_d = F_WAIT;
               cnt_d   = 2'd0;
            end
         end
         F_WAIT: begin
            // A write stealing the bus mid-wait corrupts the read, so re-request.
            if (dac_w_q) begin
               state_d = F_REQ;
            end else if (cnt_q == LAT_LAST) begin
               state_d = F_LATCH;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         F_LATCH: begin
            rbuf_d  = dac_q;
            state_d = F_IDLE;
         end
         default: ;
      endcase
      if (fetch_start) begin
         state_d = F_REQ;
      end
   end

   always_comb begin
      port_i = 8'h00;
      if (port_r) begin
         if (hit_ridx) begin
            port_i = {6'b0, mode_q ? 2'b11 : 2'b00};
         end else if (hit_widx) begin
            port_i = widx_q;
         end else if (hit_data) begin
            case (rphase_q)
               2'd0:    port_i = {2'b00, rbuf_q[15:11], rbuf_q[15]};
               2'd1:    port_i = {2'b00, rbuf_q[10:5]};
               default: port_i = {2'b00, rbuf_q[4:0], rbuf_q[4]};
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous; it is only seen on a clock edge.
      if (!reset_n) begin
         widx_q    <= 8'h00;
         ridx_q    <= 8'h00;
         wr_addr_q <= 8'h00;
         wphase_q  <= 2'd0;
         rphase_q  <= 2'd0;
         cnt_q     <= 2'd0;
         mode_q    <= 1'b0;
         dac_w_q   <= 1'b0;
         r6_q      <= 6'h00;
         g6_q      <= 6'h00;
         dac_d_q   <= 16'h0000;
         rbuf_q    <= 16'h0000;
         state_q   <= F_IDLE;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         widx_q    <= widx_d;
         ridx_q    <= ridx_d;
         wr_addr_q <= wr_addr_d;
         wphase_q  <= wphase_d;
         rphase_q  <= rphase_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         dac_w_q   <= dac_w_d;
         r6_q      <= r6_d;
         g6_q      <= g6_d;
         dac_d_q   <= dac_d_d;
         rbuf_q    <= rbuf_d;
         state_q   <= state_d;
      end
   end

endmodule

// File: tb/tb_dac_palette_ctrl.sv
// Scoreboard bench for dac_palette_ctrl: a behavioural model queues expected palette
// writes and port reads; a negedge monitor pops and compares them.
module tb_dac_palette_ctrl;

   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] port_a = 16'h0000;
   logic        port_w = 1'b0;
   logic        port_r = 1'b0;
   logic [7:0]  port_o = 8'h00;
   logic [7:0]  port_i;
   logic        port_sel;
   logic [7:0]  dac_a;
   logic [15:0] dac_d;
   logic        dac_w;
   logic [15:0] dac_q;

   always #5 clock = ~clock;

   dac_palette_ctrl #(.BASE(16'h03C0), .READ_LAT(LAT)) dut (
      .clock(clock), .reset_n(reset_n),
      .port_a(port_a), .port_w(port_w), .port_r(port_r), .port_o(port_o),
      .port_i(port_i), .port_sel(port_sel),
      .dac_a(dac_a), .dac_d(dac_d), .dac_w(dac_w), .dac_q(dac_q)
   );

   // Palette RAM model with LAT-cycle read latency and a bench preload port.
   logic [15:0] mem [256];
   logic [15:0] pipe [LAT];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = 8'h00;
   logic [15:0] pre_data = 16'h0000;

   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (dac_w) mem[dac_a] <= dac_d;
      pipe[0] <= mem[dac_a];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dac_q = pipe[LAT-1];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [23:0] wr_q [$];
   logic [7:0]  rd_q [$];

   logic        prev_w = 1'b0;
   logic [23:0] mon_e;
   always @(negedge clock) begin
      if (dac_w) begin
         check("dac_w_single_pulse", 32'(prev_w), 0);
         if (wr_q.size() == 0) check("dac_w_unexpected", 32'(wr_q.size()), 1);
         else begin
            mon_e = wr_q.pop_front();
            check("dac_a_write", 32'(dac_a), 32'(mon_e[23:16]));
            check("dac_d_write", 32'(dac_d), 32'(mon_e[15:0]));
         end
      end
      if (port_r && port_sel) begin
         if (rd_q.size() == 0) check("port_i_unexpected", 32'(rd_q.size()), 1);
         else check("port_i", 32'(port_i), 32'(rd_q.pop_front()));
      end
      prev_w = dac_w;
   end

   // Behavioural model of the register file as seen from the port bus.
   logic [15:0] shadow [256];
   logic [7:0]  m_widx, m_ridx;
   int          m_wphase, m_rphase;
   logic        m_mode;
   logic [5:0]  m_r, m_g;
   logic [15:0] m_rbuf;

   function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
      return {r[5:1], g[5:0], b[5:1]};
   endfunction

   function automatic logic [7:0] comp6(input logic [15:0] rb, input int ph);
      case (ph)
         0:       return {2'b00, rb[15:11], rb[15]};
         1:       return {2'b00, rb[10:5]};
         default: return {2'b00, rb[4:0], rb[4]};
      endcase
   endfunction

   task automatic model_reset();
      m_widx = 8'h00; m_ridx = 8'h00; m_wphase = 0; m_rphase = 0;
      m_mode = 1'b0; m_r = 6'h00; m_g = 6'h00; m_rbuf = 16'h0000;
   endtask

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
      logic [15:0] pk;
      case (a)
         16'h03C8: begin m_widx = d; m_wphase = 0; m_mode = 1'b0; end
         16'h03C7: begin m_ridx = d; m_rphase = 0; m_mode = 1'b1; m_rbuf = shadow[d]; end
         16'h03C9: begin
            if (m_wphase == 0) begin m_r = d[5:0]; m_wphase = 1; end
            else if (m_wphase == 1) begin m_g = d[5:0]; m_wphase = 2; end
            else begin
               pk = pack565({2'b00, m_r}, {2'b00, m_g}, d);
               wr_q.push_back({m_widx, pk});
               shadow[m_widx] = pk;
               m_widx = m_widx + 8'd1;
               m_wphase = 0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_read(input logic [15:0] a);
      case (a)
         16'h03C7: rd_q.push_back({6'b0, m_mode ? 2'b11 : 2'b00});
         16'h03C8: rd_q.push_back(m_widx);
         16'h03C9: begin
            rd_q.push_back(comp6(m_rbuf, m_rphase));
            if (m_rphase == 2) begin
               m_rphase = 0;
               m_ridx = m_ridx + 8'd1;
               m_rbuf = shadow[m_ridx];
            end else m_rphase++;
         end
         default: ;
      endcase
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic io_out(input logic [15:0] a, input logic [7:0] d);
      model_write(a, d);
      port_a = a; port_o = d; port_w = 1'b1;
      cyc();
      port_w = 1'b0; port_a = 16'h0000;
   endtask

   task automatic io_in(input logic [15:0] a);
      model_read(a);
      port_a = a; port_r = 1'b1;
      cyc();
      port_r = 1'b0; port_a = 16'h0000;
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d; shadow[a] = d;
      cyc();
      pre_we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
      model_reset();

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_dac_w", 32'(dac_w), 0);
      check("rst_dac_d", 32'(dac_d), 0);
      check("rst_dac_a", 32'(dac_a), 0);
      check("rst_port_sel", 32'(port_sel), 0);
      reset_n = 1'b1;
      cyc();

      // 1: single triplet write
      io_out(16'h03C8, 8'h10);
      io_out(16'h03C9, 8'h3F);
      io_out(16'h03C9, 8'h00);
      io_out(16'h03C9, 8'h15);
      idle(2);
      io_in(16'h03C8);

      // 2: prefetch and readback
      preload(8'h10, 16'hF80A);
      preload(8'h11, 16'h1234);
      io_out(16'h03C7, 8'h10);
      idle(LAT + 3);
      io_in(16'h03C9);
      io_in(16'h03C9);
      io_in(16'h03C9);
      check("t2_fetch_next", 32'(dac_a), 'h11);
      io_in(16'h03C7);
      idle(LAT + 3);
      io_in(16'h03C9);

      // 3: write index wrap
      io_out(16'h03C8, 8'hFF);
      for (int t = 0; t < 3; t++) begin
         io_out(16'h03C9, 8'(8'h05 + t));
         io_out(16'h03C9, 8'(8'h2A - t));
         io_out(16'h03C9, 8'(8'h13 * (t + 1)));
      end
      idle(2);
      io_in(16'h03C8);
      port_a = 16'h03C8;
      #1;
      check("port_i_no_strobe", 32'(port_i), 0);
      port_a = 16'h0000;

      // 4: partial triplet discarded by index write
      io_out(16'h03C9, 8'h3F);
      io_out(16'h03C9, 8'h3F);
      io_out(16'h03C8, 8'h20);
      io_out(16'h03C9, 8'h01);
      io_out(16'h03C9, 8'h02);
      io_out(16'h03C9, 8'h03);
      idle(2);

      // 5: blue write collides with fetch request
      preload(8'h30, 16'hA5C3);
      preload(8'h31, 16'h5A3C);
      io_out(16'h03C7, 8'h30);
      idle(LAT + 3);
      io_in(16'h03C9);
      io_in(16'h03C9);
      io_out(16'h03C8, 8'h50);
      io_out(16'h03C9, 8'h0A);
      io_out(16'h03C9, 8'h1B);
      model_read(16'h03C9);
      model_write(16'h03C9, 8'h2C);
      port_a = 16'h03C9; port_o = 8'h2C; port_w = 1'b1; port_r = 1'b1;
      cyc();
      port_w = 1'b0; port_r = 1'b0; port_a = 16'h0000;
      check("t5_write_first_w", 32'(dac_w), 1);
      check("t5_write_first_a", 32'(dac_a), 'h50);
      cyc();
      check("t5_fetch_delayed_a", 32'(dac_a), 'h31);
      check("t5_fetch_delayed_w", 32'(dac_w), 0);
      idle(LAT + 3);
      io_in(16'h03C9);
      io_in(16'h03C9);
      io_in(16'h03C9);

      // 6: reset mid-triplet, then foreign port strobes
      io_out(16'h03C8, 8'h40);
      io_out(16'h03C9, 8'h11);
      io_out(16'h03C9, 8'h22);
      m_wphase = 0;
      reset_n = 1'b0;
      cyc();
      cyc();
      model_reset();
      check("t6_rst_dac_w", 32'(dac_w), 0);
      check("t6_rst_dac_a", 32'(dac_a), 0);
      check("t6_rst_dac_d", 32'(dac_d), 0);
      reset_n = 1'b1;
      cyc();
      io_in(16'h03C8);
      io_in(16'h03C7);
      io_in(16'h03C9);
      port_a = 16'h0060; port_o = 8'h55; port_w = 1'b1; port_r = 1'b1;
      #1;
      check("t6_foreign_sel", 32'(port_sel), 0);
      check("t6_foreign_port_i", 32'(port_i), 0);
      cyc();
      port_w = 1'b0; port_r = 1'b0; port_a = 16'h0000;
      io_in(16'h03C8);
      io_in(16'h03C7);
      io_out(16'h03C9, 8'h01);
      io_out(16'h03C9, 8'h02);
      io_out(16'h03C9, 8'h03);
      idle(4);

      check("wr_queue_drained", 32'(wr_q.size()), 0);
      check("rd_queue_drained", 32'(rd_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
